// File: rtl/pipe_elastic_reg.sv
// pipe_elastic_reg: valid/ready elastic pipeline stage with synchronous flush and reset.
// Define PIPE_ELASTIC_REG_SKID_EN to add a second (skid) entry and a registered o_ready.
module pipe_elastic_reg #(
   parameter int DATA_WIDTH = 32,
   parameter int CTRL_WIDTH = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_flush,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [CTRL_WIDTH-1:0] i_ctrl,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [CTRL_WIDTH-1:0] o_ctrl,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [1:0]            o_occupancy
);

   // state | meaning
   // EMPTY | nothing held, main and skid invalid
   // ONE   | main entry drives the outputs
   // TWO   | main full and skid holds the next entry (skid build only)

   logic                  main_valid, main_valid_nxt;
   logic [CTRL_WIDTH-1:0] main_ctrl, main_ctrl_nxt;
   logic [DATA_WIDTH-1:0] main_data, main_data_nxt;
   logic                  accept;
   logic                  deliver;

`ifdef PIPE_ELASTIC_REG_SKID_EN
   logic                  skid_valid, skid_valid_nxt;
   logic [CTRL_WIDTH-1:0] skid_ctrl, skid_ctrl_nxt;
   logic [DATA_WIDTH-1:0] skid_data, skid_data_nxt;
   logic                  ready_q;

   assign o_ready = ready_q;
`else
   assign o_ready = !main_valid || i_ready;
`endif

   assign accept  = i_valid && o_ready;
   assign deliver = main_valid && i_ready;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         main_valid <= 1'b0;
         main_ctrl  <= '0;
         main_data  <= '0;
      end else begin
         main_valid <= main_valid_nxt;
         main_ctrl  <= main_ctrl_nxt;
         main_data  <= main_data_nxt;
      end
   end

`ifdef PIPE_ELASTIC_REG_SKID_EN
   // ready_q tracks the occupancy being loaded this edge so it equals (occupancy < 2) next cycle.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         skid_valid <= 1'b0;
         skid_ctrl  <= '0;
         skid_data  <= '0;
         ready_q    <= 1'b1;
      end else begin
         skid_valid <= skid_valid_nxt;
         skid_ctrl  <= skid_ctrl_nxt;
         skid_data  <= skid_data_nxt;
         ready_q    <= !(main_valid_nxt && skid_valid_nxt);
      end
   end
`endif

   always_comb begin
      main_valid_nxt = main_valid;
      main_ctrl_nxt  = main_ctrl;
      main_data_nxt  = main_data;
`ifdef PIPE_ELASTIC_REG_SKID_EN
      skid_valid_nxt = skid_valid;
      skid_ctrl_nxt  = skid_ctrl;
      skid_data_nxt  = skid_data;
      if (i_flush) begin
         main_valid_nxt = 1'b0;
         skid_valid_nxt = 1'b0;
      end else if (skid_valid) begin
         if (deliver) begin
            main_ctrl_nxt  = skid_ctrl;
            main_data_nxt  = skid_data;
            skid_valid_nxt = 1'b0;
         end
      end else if (main_valid) begin
         if (deliver && accept) begin
            main_ctrl_nxt = i_ctrl;
            main_data_nxt = i_data;
         end else if (deliver) begin
            main_valid_nxt = 1'b0;
         end else if (accept) begin
            skid_valid_nxt = 1'b1;
            skid_ctrl_nxt  = i_ctrl;
            skid_data_nxt  = i_data;
         end
      end else if (accept) begin
         main_valid_nxt = 1'b1;
         main_ctrl_nxt  = i_ctrl;
         main_data_nxt  = i_data;
      end
`else
      if (i_flush) begin
         main_valid_nxt = 1'b0;
      end else if (accept) begin
         main_valid_nxt = 1'b1;
         main_ctrl_nxt  = i_ctrl;
         main_data_nxt  = i_data;
      end else if (deliver) begin
         main_valid_nxt = 1'b0;
      end
`endif
   end

   always_comb begin
      o_valid = main_valid;
      o_ctrl  = main_valid ? main_ctrl : '0;
      o_data  = main_data;
`ifdef PIPE_ELASTIC_REG_SKID_EN
      o_occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
`else
      o_occupancy = {1'b0, main_valid};
`endif
   end

endmodule

// File: doc/pipe_elastic_reg.md
PIPE_ELASTIC_REG -- requirements
Module: pipe_elastic_reg

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the data payload field.
- REQ-002 SHALL have parameter CTRL_WIDTH, default 16: width of the control field; all-zero encodes NOP.
- REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
- REQ-004 SHALL have port i_reset  input  1  synchronous, active-high reset.
- REQ-005 SHALL have port i_flush  input  1  synchronous squash of all held entries.
- REQ-006 SHALL have port i_valid  input  1  upstream entry present.
- REQ-007 SHALL have port o_ready  output  1  stage can accept an entry this cycle.
- REQ-008 SHALL have port i_ctrl  input  CTRL_WIDTH  upstream control field.
- REQ-009 SHALL have port i_data  input  DATA_WIDTH  upstream data field.
- REQ-010 SHALL have port o_valid  output  1  downstream entry present.
- REQ-011 SHALL have port i_ready  input  1  downstream accepts this cycle.
- REQ-012 SHALL have port o_ctrl  output  CTRL_WIDTH  held control field.
- REQ-013 SHALL have port o_data  output  DATA_WIDTH  held data field.
- REQ-014 SHALL have port o_occupancy  output  2  number of held entries (0..2).

Function
- REQ-015 SHALL accept an entry on cycles with i_valid=1 and o_ready=1, and shall deliver one on cycles with o_valid=1 and i_ready=1.
- REQ-016 SHALL present an accepted entry on o_valid/o_ctrl/o_data one cycle after acceptance when the stage was empty or draining (latency 1).
- REQ-017 SHALL keep o_ctrl and o_data stable while o_valid=1 and i_ready=0.
- REQ-018 SHALL drive o_ctrl to all-zero whenever o_valid=0; o_data SHALL hold its last value when o_valid=0.
- REQ-019 SHALL preserve entry order; no entry is dropped or duplicated except by flush or reset.
- REQ-020 SHALL, with one held entry and simultaneous accept and deliver, replace the entry in the same cycle (full throughput, occupancy unchanged).
- REQ-021 SHALL, on a cycle with i_flush=1, set next-cycle o_valid=0, o_occupancy=0, o_ctrl=0 and discard any entry accepted that same cycle.
- REQ-022 SHALL give i_flush priority over accept/deliver; a delivery handshake on the flush cycle still counts as delivered.
- REQ-023 SHALL ignore i_ctrl/i_data when i_valid=0.

Reset
- REQ-024 SHALL, when i_reset=1 at a rising edge, set o_valid=0, o_occupancy=0, o_ctrl=0, o_data=0 and empty the skid entry.
- REQ-025 SHALL give i_reset priority over i_flush and all handshakes, including mid-transfer and when full.
- REQ-026 SHALL drive o_ready=1 from the first cycle after reset.

Configuration
- REQ-027 SHALL compile a second (skid) entry when macro PIPE_ELASTIC_REG_SKID_EN is defined.
- REQ-028 SHALL, with PIPE_ELASTIC_REG_SKID_EN defined, drive o_ready from a register equal to (occupancy<2).
- REQ-029 SHALL, with PIPE_ELASTIC_REG_SKID_EN defined, route an entry accepted while main is full and i_ready=0 into the skid entry (occupancy 2).
- REQ-030 SHALL, with PIPE_ELASTIC_REG_SKID_EN defined, promote the skid entry to the output on the next delivery.
- REQ-031 SHALL, without PIPE_ELASTIC_REG_SKID_EN, hold at most one entry, drive o_ready combinationally as (!o_valid || i_ready), and never drive o_occupancy above 1.

Verification
- REQ-032 SHALL pass stream: i_valid=1, i_ready=1, data 1,2,3,4 on consecutive cycles -> o_data 1,2,3,4 one cycle later, no bubbles.
- REQ-033 SHALL pass backpressure: hold i_ready=0 after data 0xA5 arrives, with i_ctrl=0x0003 -> o_data=0xA5 and o_ctrl=0x0003 stable until i_ready=1.
- REQ-034 SHALL pass skid (SKID_EN): send 0x10, 0x11 with i_ready=0 -> occupancy=2, o_ready=0; raise i_ready -> 0x10 then 0x11 delivered in order.
- REQ-035 SHALL pass flush: occupancy=2 and i_valid=1 with 0x22 on the flush cycle -> next cycle o_valid=0, o_ctrl=0, occupancy=0, 0x22 never appears.
- REQ-036 SHALL pass reset vs flush: i_reset=1 and i_flush=1 together while full -> all outputs per REQ-024, o_data=0, o_ready=1 the next cycle.
- REQ-037 SHALL pass no-skid build: i_ready=0 with main full -> o_ready=0 in the same cycle, occupancy never exceeds 1.
